// File: rtl/mem_stage_mc.sv
// Multi-cycle data-memory stage: one outstanding load/store with a fixed latency.
// A request is accepted in IDLE. The FSM then waits in BUSY while a down-counter
// runs out. The access commits at the edge that ends the mem_done cycle.
module mem_stage_mc #(
  parameter int unsigned WORD_LEN    = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MEM_R_EN,
  input  logic                MEM_W_EN,
  input  logic [1:0]          ACC_SIZE,
  input  logic                LD_UNSIGNED,
  input  logic [WORD_LEN-1:0] ALU_res,
  input  logic [WORD_LEN-1:0] ST_value,
  output logic [WORD_LEN-1:0] dataMem_out,
  output logic                mem_stall,
  output logic                mem_done,
  output logic                misaligned
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned CW = $clog2(MEM_LATENCY) + 1;
  localparam int unsigned NB = WORD_LEN / 8;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [AW-1:0]       idx_q;
  logic [1:0]          lane_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic                store_q;
  logic [WORD_LEN-1:0] st_q;
  logic [WORD_LEN-1:0] mem_q [MEM_DEPTH];

  logic                req;
  logic                aligned;
  logic [WORD_LEN-1:0] rd_word;
  logic [WORD_LEN-1:0] wr_word;
  logic [WORD_LEN-1:0] ld_val;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;

  // Address bits above the array index wrap around and are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^ALU_res[WORD_LEN-1:AW+2];

  // Request decode and alignment check on the live inputs.
  always_comb begin
    req = MEM_R_EN | MEM_W_EN;
    case (ACC_SIZE)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~ALU_res[0];
      default: aligned = (ALU_res[1:0] == 2'b00);
    endcase
  end

  assign misaligned = (state_q == StIdle) & req & ~aligned;
  assign mem_done   = (state_q == StBusy) & (cnt_q == '0);
  assign mem_stall  = ((state_q == StIdle) & req & aligned) |
                      ((state_q == StBusy) & (cnt_q != '0));

  assign rd_word = mem_q[idx_q];

  // Merge the store data into the addressed byte lanes of the current word.
  always_comb begin
    wr_word = rd_word;
    for (int b = 0; b < int'(NB); b++) begin
      case (size_q)
        2'b00: if (b == int'(lane_q)) wr_word[b*8 +: 8] = st_q[7:0];
        2'b01: if (b < 4 && (b / 2) == int'(lane_q[1])) wr_word[b*8 +: 8] = st_q[(b%2)*8 +: 8];
        default: wr_word[b*8 +: 8] = st_q[b*8 +: 8];
      endcase
    end
  end

  // Little-endian lane select and sign/zero extension for loads.
  always_comb begin
    ld_byte = rd_word[{lane_q, 3'b000} +: 8];
    ld_half = rd_word[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   ld_val = {{(WORD_LEN-8){~uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = {{(WORD_LEN-16){~uns_q & ld_half[15]}}, ld_half};
      default: ld_val = rd_word;
    endcase
  end

  // FSM, latency counter, request latch, memory array and load result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      lane_q      <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      store_q     <= 1'b0;
      st_q        <= '0;
      dataMem_out <= '0;
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (req && aligned) begin
            idx_q   <= ALU_res[AW+1:2];
            lane_q  <= ALU_res[1:0];
            size_q  <= ACC_SIZE;
            uns_q   <= LD_UNSIGNED;
            // Both enables together is a store.
            store_q <= MEM_W_EN;
            st_q    <= ST_value;
            cnt_q   <= CW'(MEM_LATENCY - 1);
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            state_q <= StIdle;
            if (store_q) begin
              mem_q[idx_q] <= wr_word;
            end else begin
              dataMem_out <= ld_val;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_mc.sv
// Bench for mem_stage_mc: directed scenarios plus randomized traffic against a
// byte-addressed reference memory.
module tb_mem_stage_mc;

  localparam int LAT    = 2;
  localparam int DEPTH  = 256;
  localparam int NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MEM_R_EN = 1'b0;
  logic        MEM_W_EN = 1'b0;
  logic [1:0]  ACC_SIZE = 2'b00;
  logic        LD_UNSIGNED = 1'b0;
  logic [31:0] ALU_res = '0;
  logic [31:0] ST_value = '0;
  logic [31:0] dataMem_out;
  logic        mem_stall;
  logic        mem_done;
  logic        misaligned;

  int checks   = 0;
  int failures = 0;

  byte unsigned bmem [NBYTES];
  logic [31:0]  exp_dout;

  always #5 clk = ~clk;

  mem_stage_mc #(
    .WORD_LEN   (32),
    .MEM_DEPTH  (DEPTH),
    .MEM_LATENCY(LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_R_EN   (MEM_R_EN),
    .MEM_W_EN   (MEM_W_EN),
    .ACC_SIZE   (ACC_SIZE),
    .LD_UNSIGNED(LD_UNSIGNED),
    .ALU_res    (ALU_res),
    .ST_value   (ST_value),
    .dataMem_out(dataMem_out),
    .mem_stall  (mem_stall),
    .mem_done   (mem_done),
    .misaligned (misaligned)
  );

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < NBYTES; i++) bmem[i] = 8'h00;
    exp_dout = 32'h0;
  endtask

  function automatic logic model_aligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 1'b1;
    if (sz == 2'd1) return (a % 2) == 0;
    return (a % 4) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a);
    int ba;
    int base;
    int v;
    ba = int'(a[9:0]);
    if (sz == 2'd0) begin
      v = int'(bmem[ba]);
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      base = ba - (ba % 2);
      v = int'(bmem[base]) + 256 * int'(bmem[base+1]);
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      base = ba - (ba % 4);
      return {bmem[base+3], bmem[base+2], bmem[base+1], bmem[base]};
    end
    return 32'(v);
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int ba;
    int base;
    ba = int'(a[9:0]);
    if (sz == 2'd0) begin
      bmem[ba] = d[7:0];
    end else if (sz == 2'd1) begin
      base = ba - (ba % 2);
      bmem[base]   = d[7:0];
      bmem[base+1] = d[15:8];
    end else begin
      base = ba - (ba % 4);
      bmem[base]   = d[7:0];
      bmem[base+1] = d[15:8];
      bmem[base+2] = d[23:16];
      bmem[base+3] = d[31:24];
    end
  endtask

  task automatic model_op(input logic r, input logic w, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] d, output logic emis,
                          output int ens, output int edone);
    if (!(r | w)) begin
      emis = 1'b0; ens = 0; edone = -1;
    end else if (!model_aligned(sz, a)) begin
      emis = 1'b1; ens = 0; edone = -1;
    end else begin
      emis = 1'b0; ens = LAT; edone = LAT;
      if (w) model_store(sz, a, d);
      else   exp_dout = model_load(sz, uns, a);
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; ACC_SIZE = 2'b00;
    LD_UNSIGNED = 1'b0; ALU_res = '0; ST_value = '0;
  endtask

  // Called just after a rising edge; returns once the DUT is idle again.
  task automatic run_op(input logic r, input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d, output int nstall,
                        output int done_at, output logic mis0, output logic clash,
                        output logic [31:0] dout);
    MEM_R_EN = r; MEM_W_EN = w; ACC_SIZE = sz; LD_UNSIGNED = uns; ALU_res = a; ST_value = d;
    nstall = 0; done_at = -1; clash = 1'b0;
    @(negedge clk);
    mis0 = misaligned;
    if (mem_done && misaligned) clash = 1'b1;
    if (mem_stall) nstall++;
    if (mem_done) done_at = 0;
    if (mem_stall) begin
      for (int c = 1; c <= 20 && done_at < 0; c++) begin
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        if (mem_done && misaligned) clash = 1'b1;
        if (mem_stall) nstall++;
        if (mem_done) done_at = c;
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    dout = dataMem_out;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] dout;
    int ns, da;
    logic m, cl;
    // A store request held during reset must be ignored.
    rst = 1'b1; MEM_W_EN = 1'b1; ACC_SIZE = 2'd2; ALU_res = 32'h10; ST_value = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    checks++; if (mem_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", mem_stall); end
    checks++; if (mem_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", mem_done); end
    checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL reset_mis got=%b exp=0", misaligned); end
    checks++; if (dataMem_out !== 32'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0", dataMem_out); end
    @(posedge clk); #1;
    run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, ns, da, m, cl, dout);
    checks++; if (dout !== 32'h0) begin failures++; $display("FAIL reset_mem_zero got=%h exp=0", dout); end
  endtask

  task automatic test_word_store_load();
    logic [31:0] dout;
    int ns, da;
    logic m, cl;
    run_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, ns, da, m, cl, dout);
    model_store(2'd2, 32'h10, 32'hDEADBEEF);
    checks++; if (ns !== LAT) begin failures++; $display("FAIL st_stall_cycles got=%0d exp=%0d", ns, LAT); end
    checks++; if (da !== LAT) begin failures++; $display("FAIL st_done_cycle got=%0d exp=%0d", da, LAT); end
    checks++; if (dout !== 32'h0) begin failures++; $display("FAIL st_dout_hold got=%h exp=0", dout); end
    run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, ns, da, m, cl, dout);
    exp_dout = 32'hDEADBEEF;
    checks++; if (ns !== LAT) begin failures++; $display("FAIL ld_stall_cycles got=%0d exp=%0d", ns, LAT); end
    checks++; if (da !== LAT) begin failures++; $display("FAIL ld_done_cycle got=%0d exp=%0d", da, LAT); end
    checks++; if (dout !== 32'hDEADBEEF) begin failures++; $display("FAIL ld_word got=%h exp=deadbeef", dout); end
  endtask

  task automatic test_byte_sign();
    logic [31:0] dout;
    int ns, da;
    logic m, cl;
    run_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0, ns, da, m, cl, dout);
    run_op(1'b0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h80, ns, da, m, cl, dout);
    model_store(2'd2, 32'h10, 32'h0);
    model_store(2'd0, 32'h13, 32'h80);
    run_op(1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, ns, da, m, cl, dout);
    checks++; if (dout !== 32'hFFFFFF80) begin failures++; $display("FAIL ld_byte_signed got=%h exp=ffffff80", dout); end
    run_op(1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, ns, da, m, cl, dout);
    checks++; if (dout !== 32'h00000080) begin failures++; $display("FAIL ld_byte_unsigned got=%h exp=00000080", dout); end
    run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, ns, da, m, cl, dout);
    exp_dout = 32'h80000000;
    checks++; if (dout !== 32'h80000000) begin failures++; $display("FAIL ld_word_lane3 got=%h exp=80000000", dout); end
  endtask

  task automatic test_misaligned();
    logic [31:0] dout;
    int ns, da;
    logic m, cl;
    run_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h11, 32'h0, ns, da, m, cl, dout);
    checks++; if (m !== 1'b1) begin failures++; $display("FAIL mis_half_flag got=%b exp=1", m); end
    checks++; if (ns !== 0) begin failures++; $display("FAIL mis_half_stall got=%0d exp=0", ns); end
    checks++; if (da !== -1) begin failures++; $display("FAIL mis_half_done got=%0d exp=-1", da); end
    checks++; if (dout !== 32'h80000000) begin failures++; $display("FAIL mis_half_dout got=%h exp=80000000", dout); end
    run_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h12, 32'hFFFFFFFF, ns, da, m, cl, dout);
    checks++; if (m !== 1'b1) begin failures++; $display("FAIL mis_word_flag got=%b exp=1", m); end
    run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, ns, da, m, cl, dout);
    checks++; if (dout !== 32'h80000000) begin failures++; $display("FAIL mis_mem_kept got=%h exp=80000000", dout); end
  endtask

  task automatic test_wrap();
    logic [31:0] dout;
    int ns, da;
    logic m, cl;
    run_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h400, 32'h12345678, ns, da, m, cl, dout);
    model_store(2'd2, 32'h400, 32'h12345678);
    run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, ns, da, m, cl, dout);
    exp_dout = 32'h12345678;
    checks++; if (dout !== 32'h12345678) begin failures++; $display("FAIL wrap_load got=%h exp=12345678", dout); end
  endtask

  task automatic test_reset_busy();
    logic [31:0] dout;
    int ns, da;
    logic m, cl;
    MEM_W_EN = 1'b1; ACC_SIZE = 2'd2; ALU_res = 32'h40; ST_value = 32'hCAFEF00D;
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (mem_done !== 1'b0) begin failures++; $display("FAIL rstbusy_done1 got=%b exp=0", mem_done); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++; if (mem_done !== 1'b0) begin failures++; $display("FAIL rstbusy_done2 got=%b exp=0", mem_done); end
    checks++; if (mem_stall !== 1'b0) begin failures++; $display("FAIL rstbusy_stall got=%b exp=0", mem_stall); end
    checks++; if (dataMem_out !== 32'h0) begin failures++; $display("FAIL rstbusy_dout got=%h exp=0", dataMem_out); end
    @(posedge clk); #1;
    run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, ns, da, m, cl, dout);
    checks++; if (dout !== 32'h0) begin failures++; $display("FAIL rstbusy_discard got=%h exp=0", dout); end
  endtask

  task automatic test_both_en();
    logic [31:0] dout;
    int ns, da;
    logic m, cl;
    run_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, ns, da, m, cl, dout);
    run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, ns, da, m, cl, dout);
    run_op(1'b1, 1'b1, 2'd0, 1'b1, 32'h20, 32'hFFFFFFA5, ns, da, m, cl, dout);
    model_store(2'd2, 32'h20, 32'h112233A5);
    checks++; if (da !== LAT) begin failures++; $display("FAIL both_done got=%0d exp=%0d", da, LAT); end
    checks++; if (dout !== 32'h11223344) begin failures++; $display("FAIL both_dout_hold got=%h exp=11223344", dout); end
    run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, ns, da, m, cl, dout);
    exp_dout = 32'h112233A5;
    checks++; if (dout !== 32'h112233A5) begin failures++; $display("FAIL both_store_byte got=%h exp=112233a5", dout); end
  endtask

  task automatic test_random();
    logic [31:0] dout, a, d;
    logic [1:0]  sz;
    logic        r, w, uns, m, cl, emis;
    int          ns, da, ens, eda, code;
    for (int i = 0; i < 300; i++) begin
      code = int'($urandom_range(0, 7));
      r    = (code >= 1 && code <= 3) || code == 7;
      w    = code >= 4;
      sz   = 2'($urandom_range(0, 3));
      uns  = 1'($urandom_range(0, 1));
      a    = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 3)) << 10);
      if (($urandom % 8) == 0) a = $urandom;
      d    = $urandom;
      run_op(r, w, sz, uns, a, d, ns, da, m, cl, dout);
      model_op(r, w, sz, uns, a, d, emis, ens, eda);
      checks++; if (m !== emis) begin failures++; $display("FAIL rnd_mis i=%0d a=%h sz=%0d got=%b exp=%b", i, a, sz, m, emis); end
      checks++; if (ns !== ens) begin failures++; $display("FAIL rnd_stall i=%0d got=%0d exp=%0d", i, ns, ens); end
      checks++; if (da !== eda) begin failures++; $display("FAIL rnd_done i=%0d got=%0d exp=%0d", i, da, eda); end
      checks++; if (cl !== 1'b0) begin failures++; $display("FAIL rnd_done_mis_clash i=%0d got=1 exp=0", i); end
      checks++; if (dout !== exp_dout) begin failures++; $display("FAIL rnd_dout i=%0d a=%h sz=%0d uns=%b got=%h exp=%h", i, a, sz, uns, dout, exp_dout); end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_word_store_load();
    test_byte_sign();
    test_misaligned();
    test_wrap();
    test_reset_busy();
    test_both_en();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_mc.md
MEM_STAGE_MC -- requirements
Module: mem_stage_mc

Interface
REQ-001 SHALL have parameter WORD_LEN, default 32, data/address width in bits (multiple of 8, >= 32).
REQ-002 SHALL have parameter MEM_DEPTH, default 256, number of WORD_LEN-bit words in the data array (power of two).
REQ-003 SHALL have parameter MEM_LATENCY, default 2, cycles from request acceptance to completion (>= 1).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port MEM_R_EN  input  1  load request.
REQ-007 SHALL have port MEM_W_EN  input  1  store request.
REQ-008 SHALL have port ACC_SIZE  input  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 SHALL have port LD_UNSIGNED  input  1  1 = zero-extend sub-word loads, 0 = sign-extend.
REQ-010 SHALL have port ALU_res  input  WORD_LEN  byte address.
REQ-011 SHALL have port ST_value  input  WORD_LEN  store data; sub-word data taken from its low bits.
REQ-012 SHALL have port dataMem_out  output  WORD_LEN  registered load result.
REQ-013 SHALL have port mem_stall  output  1  combinational; pipeline holds all upstream registers while high.
REQ-014 SHALL have port mem_done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port misaligned  output  1  one-cycle alignment-fault pulse.

Function
REQ-016 SHALL hold MEM_DEPTH words, indexed by ALU_res[log2(MEM_DEPTH)+1:2]; higher address bits ignored (wrap-around).
REQ-017 SHALL implement FSM IDLE/BUSY with down-counter cnt of width ceil(log2(MEM_LATENCY))+1.
REQ-018 In IDLE, request = MEM_R_EN | MEM_W_EN; if request and aligned: latch address, size, sign mode, store data, op; cnt <= MEM_LATENCY-1; go BUSY.
REQ-019 Alignment: half requires ALU_res[0]=0; word requires ALU_res[1:0]=00; byte always aligned.
REQ-020 Misaligned request in IDLE: misaligned=1 that cycle, no FSM transition, no memory change, mem_stall=0, dataMem_out unchanged.
REQ-021 mem_stall SHALL be 1 when (IDLE and aligned request) or (BUSY and cnt != 0); else 0.
REQ-022 BUSY with cnt != 0: cnt decrements each cycle; inputs ignored.
REQ-023 BUSY with cnt == 0: mem_done=1, mem_stall=0, access commits at this cycle's edge, next state IDLE; request at ALU_res in cycle T completes (mem_done) in cycle T+MEM_LATENCY.
REQ-024 Load: select byte lane ALU_res[1:0] / half lane ALU_res[1] little-endian, extend per LD_UNSIGNED, write dataMem_out at the commit edge; visible the cycle after mem_done.
REQ-025 Store: write only the addressed byte lanes; other lanes of the word unchanged.
REQ-026 MEM_R_EN and MEM_W_EN both 1: treated as store only; dataMem_out unchanged.
REQ-027 dataMem_out SHALL hold its value until the next load commits.
REQ-028 mem_done and misaligned SHALL never be 1 in the same cycle.

Reset
REQ-029 rst=1 at an edge: state IDLE, cnt 0, dataMem_out 0, all memory words 0; mem_stall, mem_done, misaligned 0 in the following cycle.
REQ-030 rst during BUSY: outstanding access aborted, pending store discarded, no mem_done.
REQ-031 rst SHALL take priority over any request in the same cycle.

Verification (MEM_LATENCY=2, WORD_LEN=32)
REQ-032 Word store 0xDEADBEEF @0x10, then word load @0x10 -> mem_stall high 2 cycles, mem_done in cycle 3 of each op, dataMem_out=0xDEADBEEF.
REQ-033 Byte store 0x80 @0x13 over 0x00000000, then signed byte load @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; word load @0x10 -> 0x80000000.
REQ-034 Half load @0x11 -> misaligned=1 one cycle, mem_stall=0, dataMem_out unchanged, memory unchanged.
REQ-035 Store 0x12345678 @0x400 (MEM_DEPTH=256) then load @0x0 -> 0x12345678 (wrap).
REQ-036 rst asserted in cycle after store accept -> no mem_done, subsequent load of that address returns 0.
REQ-037 MEM_R_EN=MEM_W_EN=1 store 0xA5 byte @0x20 -> memory byte 0xA5 written, dataMem_out unchanged.
